sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised synchronous FIFO, the successor to the basic full/empty FIFO. It uses the same extra-MSB pointer scheme and adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- an optional first-word-fall-through (FWFT) read mode.

It sits between a single-clock producer and consumer as the general-purpose buffering block.

## Interface
- Width, 8, data word width in bits (≥1)
- Depth, 16, number of entries; power of two, ≥4
- AF_LEVEL, Depth-2, almost_full asserts when count ≥ AF_LEVEL (1..Depth)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..Depth-1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- w_en  in  1  write request
- r_en  in  1  read request
- data_in  in  Width  write data
- err_clr  in  1  clears overflow/underflow
- data_out  out  Width  read data
- full  out  1  Depth entries held
- empty  out  1  zero entries held
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(Depth)+1  current occupancy, 0..Depth
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- **Pointers.** wptr and rptr are each $clog2(Depth)+1 bits.
  - The lower bits index memory.
  - The MSB toggles on wrap.
- **Full and empty.**
  - empty = (wptr == rptr).
  - full = MSBs differ and the lower bits are equal.
- **count.** count = wptr − rptr, modulo 2^($clog2(Depth)+1).
- **Write.** Accepted iff w_en && !full at the edge: mem[wptr] ← data_in, then wptr+1.
- **Read.** Accepted iff r_en && !empty at the edge: rptr+1.
- **Simultaneous w_en && r_en.**
  - Neither full nor empty: both accepted; count unchanged.
  - Full: only the read is accepted. overflow sets.
  - Empty: only the write is accepted. underflow sets.
- **Error flags.**
  - overflow sets on w_en && full.
  - underflow sets on r_en && empty.
  - Both hold until err_clr.
  - If err_clr coincides with a new error event, the flag stays set (set wins).
- **Rejected accesses.** Blocked writes and reads change no pointer and no memory contents.
- **Status outputs.** full, empty, almost_full, almost_empty and count are combinational from the pointer registers.
- **Reset (rst=1, asynchronous).**
  - wptr = rptr = 0.
  - data_out = 0 (default mode).
  - count = 0, empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0.
  - overflow = underflow = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.

## Timing
- **Write to flags.** A write at edge N is reflected in count and flags after edge N. A read can retrieve it at edge N+1.
- **Default-mode read.** data_out is registered. On an accepted read at edge N, data_out = mem[rptr] after edge N. data_out holds its value when no read is accepted.
- **Status visibility.** Flags and count reflect the pointers immediately after each edge, with no extra latency.
- **Wrap-around.** Pointers run continuously through 2×Depth values. Behaviour across the wrap is identical to non-wrap operation.

## Configuration
- **Macro:** SYNC_FIFO_FWFT_EN.
- **Defined (FWFT mode).**
  - data_out = mem[rptr] combinationally; it is valid whenever empty = 0.
  - r_en acknowledges and pops the head word.
  - After a write into an empty FIFO at edge N, the word is visible on data_out after edge N.
  - data_out is don't-care while empty.
- **Undefined (default mode).** Registered read as described under Timing, with 1-cycle latency.
- Flags, count and error behaviour are identical in both modes.

## Test plan
- Reset, then write 0,2,4,6,8, then read 5 → data_out 0,2,4,6,8 in order. count steps 1..5 then 4..0. empty is 1 at the end. With FWFT, 0 is on data_out after the first write edge.
- Write 16 words (Depth=16) → full=1 and count=16 after the 16th edge. A 17th write is ignored and overflow=1. Read 16 → original data, no loss.
- Read while empty after reset → underflow=1, rptr unchanged, data_out stays 0. Pulse err_clr → underflow=0. err_clr coinciding with another empty read → underflow stays 1.
- Fill to 14 → almost_full rises exactly at count=14. Drain to 2 → almost_empty rises exactly at count=2.
- Hold count at 8 with w_en=r_en=1 for 40 cycles (pointers wrap twice) → count stays 8 and the read sequence equals the write sequence. With the FIFO full and both asserted → only the read occurs, count=15, overflow=1.
- Assert rst for 1 ns mid-burst at count=9 → all outputs return to reset values immediately, without waiting for a clock edge. The next write/read pair returns the new data.

Source files
------------

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// sync_fifo_flags : single-clock FIFO with occupancy count, almost-full/empty,
// sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
// Rev 1.0
// ============================================================================
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic                     r_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [AW:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [AW:0] AE_THR = PW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_ok;
  logic             rd_ok;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= data_in;
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow  <= 1'b1;
      else if (err_clr)  overflow  <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem[rptr[AW-1:0]];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        data_out <= '0;
    else if (rd_ok) data_out <= mem[rptr[AW-1:0]];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo_flags : directed self-checking bench for sync_fifo_flags.
// Rev 1.0
// ============================================================================
`timescale 1ns/100ps
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .err_clr(err_clr), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops one word; in FWFT mode the head is visible before the edge.
  task automatic pop(input logic [7:0] exp, input string tag);
`ifdef SYNC_FIFO_FWFT_EN
    check(tag, data_out, exp);
    r_en = 1'b1;
    step();
`else
    r_en = 1'b1;
    step();
    check(tag, data_out, exp);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_ae"}, almost_empty, 1);
    check({tag, "_af"}, almost_full, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_unf"}, underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check({tag, "_dout"}, data_out, 0);
`endif
  endtask

  initial begin
    // Reset values while rst is held
    #12;
    check_reset_state("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Underflow on empty read, clear, set-wins
    r_en = 1'b1; step();
    check("unf_set", underflow, 1);
    check("unf_count", count, 0);
    check("unf_empty", empty, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("unf_dout", data_out, 0);
`endif
    r_en = 1'b0; err_clr = 1'b1; step();
    check("unf_clr", underflow, 0);
    r_en = 1'b1; step();
    check("unf_setwins", underflow, 1);
    r_en = 1'b0; step();
    check("unf_clr2", underflow, 0);
    err_clr = 1'b0;

    // Write 0,2,4,6,8 then read five
    w_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(2 * i);
      step();
      check("wr5_count", count, i + 1);
`ifdef SYNC_FIFO_FWFT_EN
      if (i == 0) check("fwft_first", data_out, 0);
`endif
    end
    w_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pop(8'(2 * i), "rd5_data");
      check("rd5_count", count, 4 - i);
    end
    r_en = 1'b0;
    check("rd5_empty", empty, 1);

    // Fill to full, almost_full threshold, overflow
    w_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'h10 + 8'(i);
      step();
      check("fill_count", count, i + 1);
      check("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
    end
    check("fill_full", full, 1);
    data_in = 8'hEE; step();
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    w_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pop(8'h10 + 8'(i), "drain_data");
      check("drain_ae", almost_empty, (15 - i <= 2) ? 1 : 0);
    end
    r_en = 1'b0;
    check("drain_empty", empty, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // Steady occupancy of 8 across pointer wrap
    w_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'h40 + 8'(i);
      step();
    end
    for (int k = 0; k < 40; k++) begin
      data_in = 8'h48 + 8'(k);
      pop(8'h40 + 8'(k), "wrap_data");
      check("wrap_count", count, 8);
    end
    w_en = 1'b0;
    for (int j = 0; j < 8; j++) pop(8'h68 + 8'(j), "wrap_tail");
    r_en = 1'b0;
    check("wrap_empty", empty, 1);

    // Full with both requests: only the read happens
    w_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'h80 + 8'(i);
      step();
    end
    check("both_full_pre", full, 1);
    data_in = 8'hFF;
    pop(8'h80, "both_full_data");
    w_en = 1'b0; r_en = 1'b0;
    check("both_full_count", count, 15);
    check("both_full_ovf", overflow, 1);

    // Drain to 9, then asynchronous reset mid-burst
    for (int i = 1; i < 7; i++) pop(8'h80 + 8'(i), "pre_rst_data");
    r_en = 1'b0;
    check("pre_rst_count", count, 9);
    w_en = 1'b1; data_in = 8'hA0;
    #2;
    rst = 1'b1; w_en = 1'b0;
    #0.5;
    check_reset_state("async_rst");
    #0.5;
    rst = 1'b0;
    step();
    check("post_rst_count", count, 0);

    // New data after reset
    w_en = 1'b1; data_in = 8'h5A; step(); w_en = 1'b0;
    check("post_rst_wr", count, 1);
    pop(8'h5A, "post_rst_rd");
    r_en = 1'b0;
    check("post_rst_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
